// File: rtl/goldschmidt_div_ctrl_if.sv
// Front-end bundle for the Goldschmidt divider sequencer:
// request/operands in, status and result out.
interface goldschmidt_div_ctrl_if #(
  parameter int n  = 8,
  parameter int IW = 4
);
  logic          start;
  logic [n-1:0]  dividend;
  logic [n-1:0]  divisor;
  logic [IW-1:0] iters;
  logic          busy;
  logic          done;
  logic          err;
  logic [n-1:0]  quotient;

  modport master (
    output start,
    output dividend,
    output divisor,
    output iters,
    input  busy,
    input  done,
    input  err,
    input  quotient
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    input  iters,
    output busy,
    output done,
    output err,
    output quotient
  );
endinterface

// File: rtl/goldschmidt_div_ctrl.sv
// Goldschmidt divider sequencer: N<-N*F, D<-D*F with F=2-D,
// sharing one truncating n-bit multiplier across two cycles.
module goldschmidt_div_ctrl #(
  parameter int n  = 8,
  parameter int IW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  goldschmidt_div_ctrl_if.slave  bus,
  output logic [n-1:0]           mul_in1,
  output logic [n-1:0]           mul_in2,
  input  logic [n-1:0]           mul_out
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_N,
    MUL_D,
    DONE
  } state_t;

  state_t        state;
  logic [n-1:0]  n_q;
  logic [n-1:0]  d_q;
  logic [n-1:0]  e_q;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] iters_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [n-1:0]  quot_q;

  logic [n-1:0]  n_sum;
  logic [n-1:0]  d_sum;
  logic [IW-1:0] cnt_inc;
  logic          bad_ops;

  // N<D keeps both sums below 2^n, so no carry is kept
  assign n_sum   = n_q + mul_out;
  assign d_sum   = d_q + mul_out;
  assign cnt_inc = cnt_q + 1'b1;
  assign bad_ops = !bus.divisor[n-1] ||
                   (bus.dividend >= bus.divisor);

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.quotient = quot_q;

  // Steer the shared multiplier: N*E then D*E
  always_comb begin
    mul_in1 = '0;
    mul_in2 = '0;
    unique case (1'b1)
      (state == MUL_N): begin
        mul_in1 = n_q;
        mul_in2 = e_q;
      end
      (state == MUL_D): begin
        mul_in1 = d_q;
        mul_in2 = e_q;
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered status and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      iters_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      quot_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            iters_q <= bus.iters;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (bad_ops) begin
              err_q  <= 1'b1;
              quot_q <= '1;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (bus.iters == '0) begin
              quot_q <= bus.dividend;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              n_q   <= bus.dividend;
              d_q   <= bus.divisor;
              e_q   <= '0 - bus.divisor;
              state <= MUL_N;
            end
          end
        end
        MUL_N: begin
          n_q   <= n_sum;
          state <= MUL_D;
        end
        MUL_D: begin
          d_q   <= d_sum;
          e_q   <= '0 - d_sum;
          cnt_q <= cnt_inc;
          if (cnt_inc == iters_q) begin
            quot_q <= n_q;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= MUL_N;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_div_ctrl.sv
// Scoreboard bench for goldschmidt_div_ctrl: reference model
// feeds expected multiplier traces and results to a monitor.
module tb_goldschmidt_div_ctrl;

  localparam int NW = 8;
  localparam int IW = 4;

  typedef struct {
    logic [7:0] q;
    logic       e;
    int         lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mul_in1;
  logic [7:0]  mul_in2;
  logic [7:0]  mul_out;
  logic [15:0] prod;

  int checks = 0;
  int errors = 0;
  int run    = 0;

  res_t        res_q[$];
  logic [15:0] trace_q[$];

  always #5 clk = ~clk;

  goldschmidt_div_ctrl_if #(.n(NW), .IW(IW)) bus ();

  assign prod    = 16'(mul_in1) * 16'(mul_in2);
  assign mul_out = prod[15:8];

  goldschmidt_div_ctrl #(.n(NW), .IW(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .mul_in1 (mul_in1),
    .mul_in2 (mul_in2),
    .mul_out (mul_out)
  );

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: divide by repeated scaling with F = 2 - D
  task automatic model(input logic [7:0] dd,
                       input logic [7:0] dv,
                       input logic [3:0] it);
    res_t r;
    int   nn;
    int   d;
    int   f;
    if (!dv[7] || dd >= dv) begin
      r.q = 8'hFF; r.e = 1'b1; r.lat = 1;
    end else if (it == 0) begin
      r.q = dd; r.e = 1'b0; r.lat = 1;
    end else begin
      nn = int'(dd);
      d  = int'(dv);
      for (int i = 0; i < int'(it); i++) begin
        f = 256 - d;
        trace_q.push_back({8'(nn), 8'(f)});
        nn = nn + (nn * f) / 256;
        trace_q.push_back({8'(d), 8'(f)});
        d = d + (d * f) / 256;
      end
      r.q = 8'(nn); r.e = 1'b0; r.lat = 2 * int'(it) + 1;
    end
    res_q.push_back(r);
  endtask

  task automatic issue(input logic [7:0] dd,
                       input logic [7:0] dv,
                       input logic [3:0] it);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.iters    = it;
    model(dd, dv, it);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    bus.iters    = 4'($urandom);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done");
    end
  endtask

  // Monitor: compare multiplier traffic and results
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (bus.busy) run++;
      if (bus.busy && !bus.done) begin
        if (trace_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mul: got %0h/%0h expected none",
                   mul_in1, mul_in2);
        end else begin
          logic [15:0] t;
          t = trace_q.pop_front();
          check("mul_in1", 32'(mul_in1), 32'(t[15:8]));
          check("mul_in2", 32'(mul_in2), 32'(t[7:0]));
        end
      end else if (!bus.busy) begin
        check("idle_mul", 32'({mul_in1, mul_in2}), 32'h0);
      end
      if (bus.done) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("quotient", 32'(bus.quotient), 32'(r.q));
          check("err", 32'(bus.err), 32'(r.e));
          check("busy_cycles", 32'(run), 32'(r.lat));
        end
        run = 0;
      end
    end
  end

  initial begin
    logic [7:0] dv;
    logic [7:0] dd;
    logic [3:0] it;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.iters    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_quot", 32'(bus.quotient), 32'h0);
    check("rst_in1", 32'(mul_in1), 32'h0);
    check("rst_in2", 32'(mul_in2), 32'h0);

    issue(8'h40, 8'h80, 4'd3);
    wait_done();
    check("dir_quot", 32'(bus.quotient), 32'h7F);
    check("dir_err", 32'(bus.err), 32'h0);

    issue(8'h40, 8'h80, 4'd0);
    wait_done();
    check("it0_quot", 32'(bus.quotient), 32'h40);
    check("it0_in1", 32'(mul_in1), 32'h0);
    check("it0_in2", 32'(mul_in2), 32'h0);

    issue(8'h40, 8'h7F, 4'd3);
    wait_done();
    check("unnorm_err", 32'(bus.err), 32'h1);
    check("unnorm_quot", 32'(bus.quotient), 32'hFF);

    issue(8'h90, 8'h80, 4'd2);
    wait_done();
    check("ovf_err", 32'(bus.err), 32'h1);
    check("ovf_quot", 32'(bus.quotient), 32'hFF);

    // start pulsed during MUL_D is ignored
    issue(8'h55, 8'hC3, 4'd3);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 8'h10;
    bus.divisor  = 8'h80;
    bus.iters    = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    check("b2b_err", 32'(bus.err), 32'h0);

    // start held during DONE is ignored
    bus.start    = 1'b1;
    bus.dividend = 8'h20;
    bus.divisor  = 8'hA0;
    bus.iters    = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("done_ign_busy", 32'(bus.busy), 32'h0);

    // start in the cycle right after done
    issue(8'h12, 8'h9A, 4'd2);
    wait_done();
    issue(8'h7E, 8'hE1, 4'd4);
    wait_done();

    // reset in the middle of the second iteration
    issue(8'h40, 8'h80, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    trace_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_quot", 32'(bus.quotient), 32'h0);
    check("mid_rst_in1", 32'(mul_in1), 32'h0);
    issue(8'h40, 8'h80, 4'd3);
    wait_done();
    check("post_rst_quot", 32'(bus.quotient), 32'h7F);

    for (int k = 0; k < 40; k++) begin
      dv = 8'h80 | 8'($urandom_range(0, 127));
      dd = 8'($urandom_range(0, int'(dv) - 1));
      it = 4'($urandom_range(1, 5));
      issue(dd, dv, it);
      wait_done();
    end

    for (int k = 0; k < 10; k++) begin
      dv = 8'($urandom);
      dd = 8'($urandom);
      it = 4'($urandom_range(0, 5));
      issue(dd, dv, it);
      wait_done();
    end

    @(negedge clk);
    check("trace_left", 32'(trace_q.size()), 32'h0);
    check("res_left", 32'(res_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
